// File: rtl/fp_wb_ieee_convert_pkg.sv
// fp_wb_ieee_convert_pkg: shared FPU types, FloPoCo exception encodings and IEEE constants.
package fp_wb_ieee_convert_pkg;
  typedef enum logic [1:0] {
    EXN_ZERO   = 2'b00,
    EXN_NORMAL = 2'b01,
    EXN_INF    = 2'b10,
    EXN_NAN    = 2'b11
  } exn_e;
  typedef struct packed {
    exn_e        exn;
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } flopoco_t;
  localparam int FP_ID_W = 3;
  typedef logic [FP_ID_W-1:0] id_t;
  localparam logic [31:0] CANONICAL_NAN_SP = 32'h7FC0_0000;
endpackage

// File: rtl/fp_wb_ieee_convert_flopoco_to_ieee_sp.sv
// flopoco_to_ieee_sp: combinational FloPoCo single-precision to IEEE-754 binary32 conversion.
module flopoco_to_ieee_sp
  import fp_wb_ieee_convert_pkg::*;
(
  input  flopoco_t    fp,
  output logic [31:0] ieee,
  output logic        is_nan
);
  logic [31:0] zero, inf;
  assign zero   = {fp.sign, 31'b0};
  assign inf    = {fp.sign, 8'hFF, 23'b0};
  assign is_nan = fp.exn == EXN_NAN;
  // exp extremes inside NORMAL are out of IEEE normal range: flush or saturate
  assign ieee = is_nan              ? CANONICAL_NAN_SP :
                fp.exn == EXN_INF   ? inf :
                fp.exn == EXN_ZERO  ? zero :
                fp.exp == 8'h00     ? zero :
                fp.exp == 8'hFF     ? inf :
                {fp.sign, fp.exp, fp.frac};
endmodule

// File: rtl/fp_wb_ieee_convert.sv
// fp_wb_ieee_convert: converts FloPoCo MAC results to IEEE binary32 and buffers them for writeback.
module fp_wb_ieee_convert
  import fp_wb_ieee_convert_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ID_W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_done,
  input  logic [33:0]     in_rd,
  input  logic [ID_W-1:0] in_id,
  output logic            in_ack,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [ID_W-1:0] out_id,
  output logic            out_is_nan
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [31:0]     data_q [DEPTH];
  logic [ID_W-1:0] id_q   [DEPTH];
  logic            nan_q  [DEPTH];
  flopoco_t        in_fp;
  logic [31:0]     cvt_data;
  logic            cvt_nan;
  logic            push, pop;
  assign in_fp = in_rd;
  flopoco_to_ieee_sp u_cvt (
    .fp     (in_fp),
    .ieee   (cvt_data),
    .is_nan (cvt_nan)
  );
  // in_ack depends on count only, so a pop never frees a slot in the same cycle
  assign in_ack    = count != FULL;
  assign out_valid = count != '0;
  assign push      = in_done & in_ack;
  assign pop       = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= cvt_data;
      id_q[wr_ptr]   <= in_id;
      nan_q[wr_ptr]  <= cvt_nan;
    end
  end
  assign out_data   = data_q[rd_ptr];
  assign out_id     = id_q[rd_ptr];
  assign out_is_nan = nan_q[rd_ptr];
endmodule

// File: tb/tb_fp_wb_ieee_convert.sv
// tb_fp_wb_ieee_convert: random and directed checks of DEPTH=2 and DEPTH=4 instances against a queue model.
module tb_fp_wb_ieee_convert;
  logic        clk = 1'b0;
  logic        rst, in_done, out_ready;
  logic [33:0] in_rd;
  logic [2:0]  in_id;
  logic        ack_a, ov_a, nan_a, ack_b, ov_b, nan_b;
  logic [31:0] data_a, data_b;
  logic [2:0]  id_a, id_b;
  logic [35:0] qa[$];
  logic [35:0] qb[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_wb_ieee_convert #(.DEPTH(2), .ID_W(3)) u_a (
    .clk(clk), .rst(rst), .in_done(in_done), .in_rd(in_rd), .in_id(in_id), .in_ack(ack_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(data_a), .out_id(id_a), .out_is_nan(nan_a));
  fp_wb_ieee_convert #(.DEPTH(4), .ID_W(3)) u_b (
    .clk(clk), .rst(rst), .in_done(in_done), .in_rd(in_rd), .in_id(in_id), .in_ack(ack_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(data_b), .out_id(id_b), .out_is_nan(nan_b));

  // expected buffered entry {nan, ieee, id} from the value rules of the format mapping
  function automatic logic [35:0] ref_ent(input logic [33:0] r, input logic [2:0] id);
    logic        s = r[31];
    logic [7:0]  e = r[30:23];
    logic [31:0] zero = {s, 31'b0};
    logic [31:0] inf = {s, 8'hFF, 23'b0};
    case (r[33:32])
      2'd0:    return {1'b0, zero, id};
      2'd1:    return {1'b0, (e == 8'd0) ? zero : (e == 8'd255) ? inf : r[31:0], id};
      2'd2:    return {1'b0, inf, id};
      default: return {1'b1, 32'h7FC00000, id};
    endcase
  endfunction

  function automatic logic [33:0] rand_rd();
    logic [1:0]  x = 2'($urandom_range(0, 3));
    logic [1:0]  es = 2'($urandom_range(0, 3));
    logic [7:0]  e = (es == 0) ? 8'd0 : (es == 1) ? 8'd255 : 8'($urandom);
    return {x, 1'($urandom), e, 23'($urandom)};
  endfunction

  always @(posedge clk or negedge rst) begin : model_a
    automatic bit p, q;
    if (!rst) qa.delete();
    else begin
      p = in_done && qa.size() < 2;
      q = qa.size() != 0 && out_ready;
      if (q) void'(qa.pop_front());
      if (p) qa.push_back(ref_ent(in_rd, in_id));
    end
  end

  always @(posedge clk or negedge rst) begin : model_b
    automatic bit p, q;
    if (!rst) qb.delete();
    else begin
      p = in_done && qb.size() < 4;
      q = qb.size() != 0 && out_ready;
      if (q) void'(qb.pop_front());
      if (p) qb.push_back(ref_ent(in_rd, in_id));
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_one(input string nm, input logic ov, input logic ack, input logic [35:0] out,
                         input int sz, input logic [35:0] head, input int depth);
    chk({nm, "_valid"}, 64'(ov), 64'(sz != 0));
    chk({nm, "_ack"}, 64'(ack), 64'(sz < depth));
    if (sz != 0) chk({nm, "_head"}, 64'(out), 64'(head));
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_one("a", ov_a, ack_a, {nan_a, data_a, id_a}, qa.size(), (qa.size() != 0) ? qa[0] : 36'h0, 2);
    cmp_one("b", ov_b, ack_b, {nan_b, data_b, id_b}, qb.size(), (qb.size() != 0) ? qb[0] : 36'h0, 4);
  endtask

  logic [33:0] rds [6] = '{34'h3_12345678, 34'h2_80000000, 34'h1_80123456,
                           34'h1_7F801234, 34'h0_C0A00000, 34'h1_C0490FDB};
  logic [31:0] exps [6] = '{32'h7FC00000, 32'hFF800000, 32'h80000000,
                            32'h7F800000, 32'h80000000, 32'hC0490FDB};
  logic        acks [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b0; in_done = 1'b0; out_ready = 1'b0; in_rd = '0; in_id = '0;
    repeat (2) tick();
    chk("rst_valid", 64'(ov_a), 64'(0));
    chk("rst_ack", 64'(ack_a), 64'(1));
    rst = 1'b1; in_done = 1'b1; in_rd = 34'h1_3F800000; in_id = 3'd5; out_ready = 1'b1;
    tick();
    chk("first_valid", 64'(ov_a), 64'(1));
    chk("first_data", 64'(data_a), 64'h3F800000);
    chk("first_id", 64'(id_a), 64'(5));
    in_done = 1'b0;
    tick();
    chk("first_drained", 64'(ov_a), 64'(0));
    for (int i = 0; i < 6; i++) begin
      in_done = 1'b1; in_rd = rds[i]; in_id = 3'(i);
      tick();
      chk("conv_data", 64'(data_a), 64'(exps[i]));
      chk("conv_nan", 64'(nan_a), 64'(i == 0));
    end
    in_done = 1'b0;
    tick();
    out_ready = 1'b0; in_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_rd = rand_rd(); in_id = 3'(i);
      tick();
      chk("fill_ack", 64'(ack_a), 64'(acks[i]));
    end
    in_done = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain_ack", 64'(ack_a), 64'(1));
    chk("drain_id", 64'(id_a), 64'(1));
    repeat (4) tick();
    in_done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_rd = rand_rd(); in_id = 3'(i);
      tick();
    end
    in_done = 1'b0;
    tick();
    out_ready = 1'b0; in_done = 1'b1;
    repeat (2) begin
      in_rd = rand_rd(); in_id = 3'($urandom);
      tick();
    end
    in_done = 1'b0;
    chk("held_count", 64'(ov_a && !ack_a), 64'(1));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_valid_a", 64'(ov_a), 64'(0));
    chk("async_ack_a", 64'(ack_a), 64'(1));
    chk("async_valid_b", 64'(ov_b), 64'(0));
    tick();
    #1 rst = 1'b1; out_ready = 1'b1;
    repeat (2) tick();
    chk("no_stale", 64'(ov_a), 64'(0));
    for (int i = 0; i < 400; i++) begin
      in_done = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_rd = rand_rd(); in_id = 3'($urandom);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
